// File: rtl/reg_file_wr_arbiter.sv
// ---------------------------------------------------------------------------
// reg_file_wr_arbiter
//
// Purpose:
//   Shares the single write port of reg_file between two write-back
//   requesters: req0 (ALU result) and req1 (load/mem result). It arbitrates
//   round-robin with a valid/ready handshake per requester, then registers
//   the winning write command toward reg_file with one cycle of latency. A
//   saturating counter records how many cycles both requesters were valid
//   together, for performance debug.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous, active-high reset
//   req0_valid     requester 0 has a write pending
//   req0_addr      requester 0 destination register
//   req0_data      requester 0 write data
//   req0_ready     requester 0 is granted this cycle (combinational)
//   req1_valid     requester 1 has a write pending
//   req1_addr      requester 1 destination register
//   req1_data      requester 1 write data
//   req1_ready     requester 1 is granted this cycle (combinational)
//   rf_wen         write enable to reg_file
//   rf_waddr       write address to reg_file
//   rf_wdata       write data to reg_file
//   last_grant     id of the requester granted in the last transfer
//   conflict_cnt   saturating count of cycles with both valids high
// ---------------------------------------------------------------------------
module reg_file_wr_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  last_grant,
    output logic [CNT_WIDTH-1:0]  conflict_cnt
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    // Round-robin pointer: the requester favoured when both are valid.
    logic                  prio;

    logic                  grant_p0;
    logic                  vld_p0;
    logic                  both_p0;
    logic [ADDR_WIDTH-1:0] addr_p0;
    logic [DATA_WIDTH-1:0] data_p0;

    // ---- stage p0: combinational arbitration and command select ----
    always_comb begin
        grant_p0 = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_p0 = prio;
        end else if (req1_valid) begin
            grant_p0 = 1'b1;
        end
    end

    // Ready is masked by rst so a request seen during reset never looks
    // accepted to the requester (its transfer is discarded).
    assign req0_ready = !rst && req0_valid && !grant_p0;
    assign req1_ready = !rst && req1_valid &&  grant_p0;
    assign vld_p0     = req0_ready || req1_ready;
    assign both_p0    = req0_valid && req1_valid;
    assign addr_p0    = grant_p0 ? req1_addr : req0_addr;
    assign data_p0    = grant_p0 ? req1_data : req0_data;

    // ---- stage p1: registered write command, pointer and counter ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_wen       <= 1'b0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
            last_grant   <= 1'b0;
            prio         <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            // A write to r0 completes its handshake but never enables the
            // reg_file write, so r0 stays zero.
            rf_wen <= vld_p0 && (addr_p0 != '0);
            if (vld_p0) begin
                rf_waddr   <= addr_p0;
                rf_wdata   <= data_p0;
                last_grant <= grant_p0;
                prio       <= ~grant_p0;
            end
            if (both_p0 && (conflict_cnt != CNT_MAX)) begin
                conflict_cnt <= conflict_cnt + 1'b1;
            end
        end
    end

endmodule
